// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants for the multi-channel clock divider.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

   // Smallest divisor a channel accepts; N=1 would leave no low phase
   localparam int unsigned MIN_DIV     = 2;
   // Default divisor width and reset divisor
   localparam int unsigned DEF_DW      = 16;
   localparam int unsigned DEF_DIVISOR = 100;
   // Width of the channel index on the configuration port (up to 8 channels)
   localparam int unsigned CH_IDX_W    = 3;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ch
//  Description : One divider channel: active/shadow divisor, down-counter,
//                registered tick strobe and square-wave output.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned DW      = DEF_DW,
   parameter int unsigned DEF_DIV = DEF_DIVISOR
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          en_i,
   input  logic          sync_i,
   input  logic          wr_i,
   input  logic [DW-1:0] div_i,
   output logic          pending_o,
   output logic          tick_o,
   output logic          sq_o
);

   localparam logic [DW-1:0] c_rst_div = DW'(DEF_DIV);
   localparam logic [DW-1:0] c_one     = DW'(1);

   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] s_q, s_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          tick_q, tick_d;
   logic          sq_q, sq_d;
   logic          w_tc;
   logic          w_reload;

   // Next-state: divisor hand-over happens only at a period boundary (terminal
   // count or sync) or while idle, so a running period is never cut short.
   always_comb begin
      a_d      = a_q;
      s_d      = s_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      w_tc     = en_i && (cnt_q == '0);
      w_reload = en_i && (w_tc || sync_i);

      if (wr_i) begin
         s_d    = div_i;
         pend_d = 1'b1;
      end

      if (w_reload) begin
         // A write landing on the reload cycle is taken directly (bypass)
         if (wr_i) begin
            a_d = div_i;
         end else if (pend_q) begin
            a_d = s_q;
         end
         pend_d = 1'b0;
         cnt_d  = a_d - c_one;
      end else if (!en_i) begin
         if (pend_q && !wr_i) begin
            a_d    = s_q;
            pend_d = 1'b0;
         end
         cnt_d = a_d - c_one;
      end else begin
         cnt_d = cnt_q - c_one;
      end

      tick_d = w_tc;
      // High for the upper half of the count: ceil(A/2) high, floor(A/2) low
      sq_d   = en_i && (cnt_d >= (a_d >> 1));
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         a_q    <= c_rst_div;
         s_q    <= c_rst_div;
         cnt_q  <= c_rst_div - c_one;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         a_q    <= a_d;
         s_q    <= s_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign pending_o = pend_q;
   assign tick_o    = tick_q;
   assign sq_o      = sq_q;

endmodule : clk_div_ch
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : NCH independent programmable clock dividers sharing one
//                configuration port and a common phase-align pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned NCH     = 2,
   parameter int unsigned DW      = DEF_DW,
   parameter int unsigned DEF_DIV = DEF_DIVISOR
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [NCH-1:0]      en,
   input  logic                sync,
   input  logic                cfg_wr,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [DW-1:0]       cfg_div,
   output logic                cfg_err,
   output logic [NCH-1:0]      pending,
   output logic [NCH-1:0]      tick,
   output logic [NCH-1:0]      sq
);

   localparam int unsigned c_cmp_w = CH_IDX_W + 1;

   logic w_ch_ok;
   logic w_div_ok;
   logic w_wr_ok;
   logic w_wr_bad;
   logic cfg_err_q;

   // Extra index bit so NCH=8 compares correctly
   assign w_ch_ok  = ({1'b0, cfg_ch} < c_cmp_w'(NCH));
   assign w_div_ok = (cfg_div >= DW'(MIN_DIV));
   assign w_wr_ok  = cfg_wr && w_ch_ok && w_div_ok;
   assign w_wr_bad = cfg_wr && !(w_ch_ok && w_div_ok);

   // Rejected writes raise a single-cycle error pulse on the following cycle
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= w_wr_bad;
      end
   end

   assign cfg_err = cfg_err_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clk_div_ch #(
         .DW      (DW),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk_i     (sys_clk),
         .rst_n_i   (sys_rst_n),
         .en_i      (en[i]),
         .sync_i    (sync),
         .wr_i      (w_wr_ok && (cfg_ch == CH_IDX_W'(i))),
         .div_i     (cfg_div),
         .pending_o (pending[i]),
         .tick_o    (tick[i]),
         .sq_o      (sq[i])
      );
   end : g_ch

endmodule : clk_div_multi
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Self-checking bench for clk_div_multi with a period-position
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_multi;

   localparam int NCH     = 2;
   localparam int DW      = 16;
   localparam int DEF_DIV = 100;

   logic           sys_clk   = 1'b0;
   logic           sys_rst_n = 1'b0;
   logic [NCH-1:0] en        = '0;
   logic           sync      = 1'b0;
   logic           cfg_wr    = 1'b0;
   logic [2:0]     cfg_ch    = '0;
   logic [DW-1:0]  cfg_div   = '0;
   logic           cfg_err;
   logic [NCH-1:0] pending;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sq;

   clk_div_multi #(
      .NCH     (NCH),
      .DW      (DW),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (en),
      .sync      (sync),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .pending   (pending),
      .tick      (tick),
      .sq        (sq)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: per channel the position within the current period
   // (0..A-1), the active/shadow divisors and the pending flag.
   int             m_a   [NCH];
   int             m_s   [NCH];
   int             m_pos [NCH];
   bit             m_pend[NCH];
   logic [NCH-1:0] exp_tick = '0;
   logic [NCH-1:0] exp_sq   = '0;
   logic [NCH-1:0] exp_pend = '0;
   logic           exp_err  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
      end
   endtask

   function automatic void model_step();
      bit wv;
      if (!sys_rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_a[c] = DEF_DIV; m_s[c] = DEF_DIV; m_pos[c] = 0; m_pend[c] = 0;
         end
         exp_tick = '0; exp_sq = '0; exp_pend = '0; exp_err = 1'b0;
      end else begin
         wv      = cfg_wr && (int'(cfg_ch) < NCH) && (int'(cfg_div) >= 2);
         exp_err = cfg_wr && !wv;
         for (int c = 0; c < NCH; c++) begin
            bit wr;
            bit last;
            wr   = wv && (int'(cfg_ch) == c);
            last = en[c] && (m_pos[c] == m_a[c] - 1);
            exp_tick[c] = last;
            if (en[c] && (last || sync)) begin
               if (wr) begin
                  m_a[c] = int'(cfg_div); m_s[c] = int'(cfg_div);
               end else if (m_pend[c]) begin
                  m_a[c] = m_s[c];
               end
               m_pend[c] = 0;
               m_pos[c]  = 0;
            end else begin
               if (wr) begin
                  m_s[c] = int'(cfg_div); m_pend[c] = 1;
               end else if (!en[c] && m_pend[c]) begin
                  m_a[c] = m_s[c]; m_pend[c] = 0;
               end
               m_pos[c] = en[c] ? m_pos[c] + 1 : 0;
            end
            exp_sq[c]   = en[c] && (m_pos[c] < (m_a[c] + 1) / 2);
            exp_pend[c] = m_pend[c];
         end
      end
   endfunction

   // One clock: model advances on the edge, outputs compared 1 time unit later,
   // control returns at the falling edge where new inputs are driven.
   task automatic cyc();
      @(posedge sys_clk);
      model_step();
      #1;
      check_eq("tick",    32'(tick),    32'(exp_tick));
      check_eq("sq",      32'(sq),      32'(exp_sq));
      check_eq("pending", 32'(pending), 32'(exp_pend));
      check_eq("cfg_err", 32'(cfg_err), 32'(exp_err));
      @(negedge sys_clk);
   endtask

   task automatic wait_tick(input int ch, input int maxc, output int n);
      bit done;
      n    = 0;
      done = 0;
      while (!done) begin
         cyc();
         n++;
         if (tick[ch]) begin
            done = 1;
         end else if (n >= maxc) begin
            check_eq("wait_tick_timeout", 32'(tick[ch]), 32'd1);
            done = 1;
         end
      end
   endtask

   task automatic count_sq(input int ch, input int ncyc, output int hi);
      hi = 0;
      repeat (ncyc) begin
         cyc();
         if (sq[ch]) hi++;
      end
   endtask

   task automatic write_cfg(input int ch, input int div);
      cfg_wr  = 1'b1;
      cfg_ch  = 3'(ch);
      cfg_div = DW'(div);
      cyc();
      cfg_wr  = 1'b0;
   endtask

   initial begin
      int n;
      int hi;
      int f0;
      int f1;

      // Reset
      sys_rst_n = 1'b0;
      en        = '0;
      cfg_wr    = 1'b1;   // must be ignored during reset
      cfg_ch    = 3'd0;
      cfg_div   = 16'd5;
      sync      = 1'b1;
      repeat (3) cyc();
      cfg_wr = 1'b0;
      sync   = 1'b0;
      check_eq("rst_pending", 32'(pending), 32'd0);
      check_eq("rst_tick",    32'(tick),    32'd0);
      check_eq("rst_sq",      32'(sq),      32'd0);
      check_eq("rst_err",     32'(cfg_err), 32'd0);

      // Default divisor on both channels
      sys_rst_n = 1'b1;
      en        = 2'b11;
      wait_tick(0, 150, n);
      check_eq("first_tick_ch0", 32'(n), 32'd100);
      check_eq("first_tick_ch1", 32'(tick[1]), 32'd1);
      wait_tick(0, 150, n);
      check_eq("period_100", 32'(n), 32'd100);
      count_sq(0, 100, hi);
      check_eq("sq_high_100", 32'(hi), 32'd50);

      // Mid-period write of N=7 on channel 0
      repeat (30) cyc();
      write_cfg(0, 7);
      check_eq("pending_after_wr", 32'(pending[0]), 32'd1);
      wait_tick(0, 150, n);
      check_eq("old_period_done", 32'(n), 32'd69);
      check_eq("pending_applied", 32'(pending[0]), 32'd0);
      wait_tick(0, 20, n);
      check_eq("period_7", 32'(n), 32'd7);
      count_sq(0, 7, hi);
      check_eq("sq_high_7", 32'(hi), 32'd4);

      // Rejected writes
      write_cfg(1, 1);
      check_eq("err_div1", 32'(cfg_err), 32'd1);
      check_eq("err_div1_pend", 32'(pending[1]), 32'd0);
      cyc();
      check_eq("err_clears", 32'(cfg_err), 32'd0);
      write_cfg(5, 9);
      check_eq("err_ch5", 32'(cfg_err), 32'd1);
      check_eq("err_ch5_pend", 32'(pending), 32'd0);

      // Sync alignment with N=2 / N=3
      write_cfg(0, 2);
      write_cfg(1, 3);
      repeat (220) cyc();
      check_eq("both_applied", 32'(pending), 32'd0);
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      f0 = -1;
      f1 = -1;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (tick[0] && f0 < 0) f0 = k;
         if (tick[1] && f1 < 0) f1 = k;
      end
      check_eq("sync_next_ch0", 32'(f0), 32'd2);
      check_eq("sync_next_ch1", 32'(f1), 32'd3);

      // Sync coinciding with a terminal count still ticks
      for (int k = 0; k < 6 && m_pos[0] != 1; k++) cyc();
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      check_eq("sync_tc_tick", 32'(tick[0]), 32'd1);

      // Write in the exact terminal-count cycle governs the next period
      for (int k = 0; k < 6 && m_pos[0] != 1; k++) cyc();
      write_cfg(0, 5);
      check_eq("bypass_tick", 32'(tick[0]), 32'd1);
      check_eq("bypass_nopend", 32'(pending[0]), 32'd0);
      wait_tick(0, 20, n);
      check_eq("bypass_period", 32'(n), 32'd5);

      // Reset mid-period with a pending write
      repeat (2) cyc();
      write_cfg(1, 9);
      sys_rst_n = 1'b0;
      cyc();
      check_eq("midrst_tick", 32'(tick), 32'd0);
      check_eq("midrst_sq", 32'(sq), 32'd0);
      check_eq("midrst_pend", 32'(pending), 32'd0);
      sys_rst_n = 1'b1;
      wait_tick(0, 150, n);
      check_eq("midrst_period", 32'(n), 32'd100);

      // Largest divisor on channel 1
      write_cfg(1, 65535);
      wait_tick(1, 150, n);
      check_eq("max_div_applied", 32'(pending[1]), 32'd0);
      repeat (300) cyc();

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         int r;
         r = int'($urandom_range(0, 999));
         sys_rst_n = (r < 3) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 99) < 4) en[$urandom_range(0, NCH-1)] ^= 1'b1;
         sync   = ($urandom_range(0, 99) < 2);
         cfg_wr = ($urandom_range(0, 99) < 6);
         cfg_ch = 3'($urandom_range(0, 7));
         r = int'($urandom_range(0, 99));
         if (r < 10)      cfg_div = DW'($urandom_range(0, 1));
         else if (r < 95) cfg_div = DW'($urandom_range(2, 12));
         else             cfg_div = DW'($urandom);
         cyc();
      end
      sys_rst_n = 1'b1;
      sync      = 1'b0;
      cfg_wr    = 1'b0;
      repeat (5) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_clk_div_multi
`default_nettype wire
